// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Holds the R-type funct codes that touch HI/LO, the sequencer state type,
// the operation encoding passed to the datapath, and a magnitude helper.
package muldiv_ctrl_pkg;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    // Every funct that reads or writes HI/LO; any of these in EX stalls while busy.
    localparam logic [5:0] HILO_FUNCTS [0:7] = '{
        FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO,
        FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU
    };

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_t;

    // Encoding equals funct[1:0] of the corresponding instruction.
    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } md_op_t;

    // Absolute value for signed operands; unsigned operands pass through.
    // 32'h80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative multiply/divide datapath.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             latch operand magnitudes and sign flags for op
//   op                operation (md_op_t encoding, funct[1:0])
//   step              perform one iteration this cycle
//   finish            last iteration; internal state is cleared at this edge
//   rs_val, rt_val    operands (rs = multiplier / dividend, rt = multiplicand / divisor)
//   res_hi, res_lo    sign-corrected result of the step happening this cycle,
//                     valid while finish is high
module muldiv_core
    import muldiv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic        step,
    input  logic        finish,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo
);

    logic        op_signed;
    logic        is_div_reg, neg_q_reg, neg_r_reg;
    logic [63:0] acc_reg, acc_next;       // product accumulator
    logic [63:0] mcand_reg, mcand_next;   // multiplicand, shifted left each step
    logic [31:0] opa_reg, opa_next;       // multiplier (mult) / dividend -> quotient (div)
    logic [31:0] rem_reg, rem_next;       // partial remainder, always < divisor after a step
    logic [31:0] divisor_reg;
    logic [32:0] rem_shift;               // 33-bit trial remainder
    logic [31:0] rem_sub;
    logic        fits;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;

    assign op_signed = (op == OP_MULT) || (op == OP_DIV);

    always_comb begin
        acc_next   = acc_reg;
        mcand_next = mcand_reg;
        opa_next   = opa_reg;
        rem_next   = rem_reg;
        rem_shift  = {rem_reg, opa_reg[31]};
        fits       = (rem_shift >= {1'b0, divisor_reg});
        // True difference is below the divisor when it fits, so 32 bits suffice.
        rem_sub    = rem_shift[31:0] - divisor_reg;
        if (is_div_reg) begin
            rem_next = fits ? rem_sub : rem_shift[31:0];
            opa_next = {opa_reg[30:0], fits};
        end else begin
            acc_next   = acc_reg + (opa_reg[0] ? mcand_reg : 64'd0);
            mcand_next = {mcand_reg[62:0], 1'b0};
            opa_next   = {1'b0, opa_reg[31:1]};
        end
    end

    // Sign fix-up is applied to the values produced by the current step so the
    // final step's result can be written to HI/LO at the same edge.
    always_comb begin
        prod_fix = neg_q_reg ? (~acc_next + 64'd1) : acc_next;
        quo_fix  = neg_q_reg ? (~opa_next + 32'd1) : opa_next;
        rem_fix  = neg_r_reg ? (~rem_next + 32'd1) : rem_next;
        if (is_div_reg) begin
            res_hi = rem_fix;
            res_lo = quo_fix;
        end else begin
            res_hi = prod_fix[63:32];
            res_lo = prod_fix[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || finish) begin
            is_div_reg  <= 1'b0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            acc_reg     <= 64'd0;
            mcand_reg   <= 64'd0;
            opa_reg     <= 32'd0;
            rem_reg     <= 32'd0;
            divisor_reg <= 32'd0;
        end else if (start) begin
            is_div_reg  <= op[1];
            neg_q_reg   <= op_signed & (rs_val[31] ^ rt_val[31]);
            neg_r_reg   <= op_signed & rs_val[31];
            acc_reg     <= 64'd0;
            mcand_reg   <= {32'd0, magnitude(rt_val, op_signed)};
            opa_reg     <= magnitude(rs_val, op_signed);
            rem_reg     <= 32'd0;
            divisor_reg <= magnitude(rt_val, op_signed);
        end else if (step) begin
            acc_reg   <= acc_next;
            mcand_reg <= mcand_next;
            opa_reg   <= opa_next;
            rem_reg   <= rem_next;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer and HI/LO owner for the EX stage.
// Ports:
//   clk, rst_n        pipeline clock, synchronous active-low reset
//   ex_inst, ex_valid instruction in ID/EX and its valid flag (0 = bubble)
//   rs_val, rt_val    forwarded operands in EX
//   stall             combinational: HI/LO user in EX while an iteration runs
//   busy              registered: 32-step iteration in progress
//   hi_o, lo_o        HI and LO registers
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ex_inst,
    input  logic        ex_valid,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        stall,
    output logic        busy,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    logic        is_rtype;
    logic [5:0]  funct;
    logic [7:0]  hilo_hit;
    logic        uses_hilo, is_muldiv, is_mthi, is_mtlo, div_by_zero;
    logic        start, step, finish;
    md_state_t   state_reg;
    logic [4:0]  cnt_reg;
    logic [31:0] hi_reg, lo_reg;
    logic [31:0] res_hi, res_lo;
    logic        unused_inst_bits;

    assign is_rtype = ex_valid && (ex_inst[31:26] == 6'd0);
    assign funct    = ex_inst[5:0];
    assign unused_inst_bits = ^ex_inst[25:6];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_hilo_dec
            assign hilo_hit[gi] = is_rtype && (funct == HILO_FUNCTS[gi]);
        end
    endgenerate

    assign uses_hilo   = |hilo_hit;
    // MULT/MULTU/DIV/DIVU are 6'h18..6'h1B; bit 1 selects divide.
    assign is_muldiv   = is_rtype && (funct[5:2] == 4'b0110);
    assign is_mthi     = is_rtype && (funct == FUNCT_MTHI);
    assign is_mtlo     = is_rtype && (funct == FUNCT_MTLO);
    assign div_by_zero = is_muldiv && funct[1] && (rt_val == 32'd0);

    assign busy   = (state_reg == ST_BUSY);
    assign stall  = busy && uses_hilo;
    assign start  = (state_reg == ST_IDLE) && is_muldiv && !div_by_zero;
    assign step   = (state_reg == ST_BUSY);
    assign finish = step && (cnt_reg == 5'd31);
    assign hi_o   = hi_reg;
    assign lo_o   = lo_reg;

    muldiv_core u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (funct[1:0]),
        .step   (step),
        .finish (finish),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 5'd0;
            hi_reg    <= 32'd0;
            lo_reg    <= 32'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (div_by_zero) begin
                        // Resolved immediately without iterating.
                        hi_reg <= rs_val;
                        lo_reg <= 32'hFFFF_FFFF;
                    end else if (is_muldiv) begin
                        cnt_reg   <= 5'd0;
                        state_reg <= ST_BUSY;
                    end else if (is_mthi) begin
                        hi_reg <= rs_val;
                    end else if (is_mtlo) begin
                        lo_reg <= rs_val;
                    end
                end
                ST_BUSY: begin
                    cnt_reg <= cnt_reg + 5'd1;
                    if (cnt_reg == 5'd31) begin
                        hi_reg    <= res_hi;
                        lo_reg    <= res_lo;
                        cnt_reg   <= 5'd0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ex_inst;
    logic        ex_valid;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        stall;
    logic        busy;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int checks   = 0;
    int failures = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    muldiv_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ex_inst  (ex_inst),
        .ex_valid (ex_valid),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .stall    (stall),
        .busy     (busy),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rinst(input logic [5:0] f);
        logic [19:0] mid;
        mid = 20'($urandom);
        return {6'd0, mid, f};
    endfunction

    // Reference: HI/LO from plain 64-bit arithmetic.
    task automatic ref_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] h, output logic [31:0] l);
        logic signed [63:0] sa, sb, sp, sq, sr;
        logic [63:0] ua, ub, up, uq, ur;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        h = 32'd0;
        l = 32'd0;
        case (f)
            F_MULT: begin
                sp = sa * sb;
                h = sp[63:32]; l = sp[31:0];
            end
            F_MULTU: begin
                up = ua * ub;
                h = up[63:32]; l = up[31:0];
            end
            F_DIV: begin
                if (b == 32'd0) begin
                    h = a; l = 32'hFFFF_FFFF;
                end else begin
                    sq = sa / sb; sr = sa % sb;
                    h = sr[31:0]; l = sq[31:0];
                end
            end
            default: begin
                if (b == 32'd0) begin
                    h = a; l = 32'hFFFF_FFFF;
                end else begin
                    uq = ua / ub; ur = ua % ub;
                    h = ur[31:0]; l = uq[31:0];
                end
            end
        endcase
    endtask

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        ex_inst  = rinst(f);
        ex_valid = 1'b1;
        rs_val   = a;
        rt_val   = b;
    endtask

    task automatic idle_inputs;
        ex_inst  = $urandom;
        ex_valid = 1'b0;
        rs_val   = $urandom;
        rt_val   = $urandom;
    endtask

    // Issue one mult/div to an idle unit, count busy cycles, check HI/LO hold and result.
    task automatic run_muldiv(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh, el;
        int n, exp_n;
        ref_op(f, a, b, eh, el);
        exp_n = ((f == F_DIV || f == F_DIVU) && b == 32'd0) ? 0 : 32;
        issue(f, a, b);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL issue_stall f=%h got=%b want=0", f, stall);
        end
        tick;
        idle_inputs;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            checks++;
            if (hi_o !== m_hi || lo_o !== m_lo) begin
                failures++;
                $display("FAIL hilo_hold cyc=%0d got=%h_%h want=%h_%h", n, hi_o, lo_o, m_hi, m_lo);
            end
            n++;
            tick;
        end
        checks++;
        if (n !== exp_n) begin
            failures++;
            $display("FAIL busy_cycles f=%h got=%0d want=%0d", f, n, exp_n);
        end
        m_hi = eh;
        m_lo = el;
        checks++;
        if (hi_o !== eh || lo_o !== el) begin
            failures++;
            $display("FAIL result f=%h rs=%h rt=%h got=%h_%h want=%h_%h", f, a, b, hi_o, lo_o, eh, el);
        end
        $display("op f=%h rs=%h rt=%h busy_cycles=%0d hi=%h lo=%h", f, a, b, n, hi_o, lo_o);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle_inputs;
        tick;
        tick;
        issue(F_MFLO, 32'd0, 32'd0);
        #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b want=0", stall); end
        checks++;
        if (hi_o !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h want=0", hi_o); end
        checks++;
        if (lo_o !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h want=0", lo_o); end
        $display("reset busy=%b stall=%b hi=%h lo=%h", busy, stall, hi_o, lo_o);
        rst_n = 1'b1;
        idle_inputs;
        tick;
    endtask

    task automatic test_mt;
        logic [31:0] v;
        v = $urandom;
        issue(F_MTHI, v, $urandom);
        tick;
        idle_inputs;
        m_hi = v;
        checks++;
        if (hi_o !== m_hi || lo_o !== m_lo) begin
            failures++;
            $display("FAIL mthi got=%h_%h want=%h_%h", hi_o, lo_o, m_hi, m_lo);
        end
        $display("mthi rs=%h hi=%h lo=%h", v, hi_o, lo_o);
        v = $urandom;
        issue(F_MTLO, v, $urandom);
        tick;
        idle_inputs;
        m_lo = v;
        checks++;
        if (hi_o !== m_hi || lo_o !== m_lo) begin
            failures++;
            $display("FAIL mtlo got=%h_%h want=%h_%h", hi_o, lo_o, m_hi, m_lo);
        end
        $display("mtlo rs=%h hi=%h lo=%h", v, hi_o, lo_o);
    endtask

    task automatic test_directed;
        run_muldiv(F_MULT,  32'hFFFF_FFFE, 32'd3);
        run_muldiv(F_MULTU, 32'hFFFF_FFFE, 32'd3);
        run_muldiv(F_DIV,   32'hFFFF_FFF9, 32'd2);
        run_muldiv(F_DIVU,  32'd100, 32'd7);
        run_muldiv(F_DIVU,  32'd7, 32'd0);
        run_muldiv(F_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        run_muldiv(F_MULT,  32'h8000_0000, 32'h8000_0000);
    endtask

    task automatic test_random;
        logic [5:0]  f;
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            case ($urandom % 4)
                0: f = F_MULT;
                1: f = F_MULTU;
                2: f = F_DIV;
                default: f = F_DIVU;
            endcase
            a = ($urandom % 6 == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom % 8)
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFF_FFFF;
                3: b = 32'h8000_0000;
                default: b = $urandom;
            endcase
            run_muldiv(f, a, b);
        end
    endtask

    // MULT at T, MFLO at T+1: stalled through T+32, sees the product at T+33.
    task automatic test_stall_hilo;
        logic [31:0] a, b, eh, el;
        int n;
        a = $urandom;
        b = $urandom;
        ref_op(F_MULT, a, b, eh, el);
        issue(F_MULT, a, b);
        tick;
        issue(F_MFLO, $urandom, $urandom);
        #1;
        n = 0;
        while (stall === 1'b1 && n < 40) begin
            n++;
            tick;
            #1;
        end
        checks++;
        if (n !== 32) begin failures++; $display("FAIL mflo_stall_cycles got=%0d want=32", n); end
        m_hi = eh;
        m_lo = el;
        checks++;
        if (lo_o !== el) begin failures++; $display("FAIL mflo_value got=%h want=%h", lo_o, el); end
        $display("mflo_after_mult stall_cycles=%0d lo=%h", n, lo_o);
        idle_inputs;
        tick;
    endtask

    task automatic test_free_flow;
        logic [31:0] a, b, eh, el;
        int n;
        a = $urandom;
        b = $urandom;
        ref_op(F_MULTU, a, b, eh, el);
        issue(F_MULTU, a, b);
        tick;
        issue(F_ADD, $urandom, $urandom);
        #1;
        checks++;
        if (stall !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL add_while_busy got stall=%b busy=%b want stall=0 busy=1", stall, busy);
        end
        tick;
        ex_inst  = rinst(F_MFLO);
        ex_valid = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL bubble_stall got=%b want=0", stall); end
        tick;
        ex_inst  = {6'h23, 20'($urandom), F_MFHI};
        ex_valid = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL non_rtype_stall got=%b want=0", stall); end
        ex_inst = rinst(F_MTLO);
        #1;
        checks++;
        if (stall !== 1'b1) begin failures++; $display("FAIL mtlo_stall got=%b want=1", stall); end
        idle_inputs;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            tick;
        end
        m_hi = eh;
        m_lo = el;
        checks++;
        if (hi_o !== eh || lo_o !== el) begin
            failures++;
            $display("FAIL free_flow_result got=%h_%h want=%h_%h", hi_o, lo_o, eh, el);
        end
        $display("free_flow result hi=%h lo=%h", hi_o, lo_o);
    endtask

    task automatic test_back_to_back;
        logic [31:0] a1, b1, a2, b2, eh1, el1, eh2, el2;
        int n;
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
        ref_op(F_MULT, a1, b1, eh1, el1);
        ref_op(F_MULT, a2, b2, eh2, el2);
        issue(F_MULT, a1, b1);
        tick;
        issue(F_MULT, a2, b2);
        #1;
        n = 0;
        while (stall === 1'b1 && n < 40) begin
            n++;
            tick;
            #1;
        end
        checks++;
        if (n !== 32) begin failures++; $display("FAIL b2b_stall_cycles got=%0d want=32", n); end
        checks++;
        if (hi_o !== eh1 || lo_o !== el1) begin
            failures++;
            $display("FAIL b2b_first got=%h_%h want=%h_%h", hi_o, lo_o, eh1, el1);
        end
        m_hi = eh1;
        m_lo = el1;
        tick;
        idle_inputs;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            tick;
        end
        checks++;
        if (n !== 32) begin failures++; $display("FAIL b2b_busy_cycles got=%0d want=32", n); end
        m_hi = eh2;
        m_lo = el2;
        checks++;
        if (hi_o !== eh2 || lo_o !== el2) begin
            failures++;
            $display("FAIL b2b_second got=%h_%h want=%h_%h", hi_o, lo_o, eh2, el2);
        end
        $display("back_to_back second hi=%h lo=%h", hi_o, lo_o);
    endtask

    task automatic test_reset_mid;
        issue(F_DIV, $urandom, 32'($urandom_range(1, 1000)));
        tick;
        idle_inputs;
        repeat (9) tick;
        rst_n = 1'b0;
        tick;
        issue(F_MFLO, $urandom, $urandom);
        #1;
        checks++;
        if (busy !== 1'b0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL midreset_ctrl got busy=%b stall=%b want 0 0", busy, stall);
        end
        checks++;
        if (hi_o !== 32'd0 || lo_o !== 32'd0) begin
            failures++;
            $display("FAIL midreset_hilo got=%h_%h want=0_0", hi_o, lo_o);
        end
        m_hi = 32'd0;
        m_lo = 32'd0;
        rst_n = 1'b1;
        idle_inputs;
        tick;
        issue(F_MTHI, 32'h1234_5678, $urandom);
        tick;
        idle_inputs;
        m_hi = 32'h1234_5678;
        checks++;
        if (hi_o !== m_hi || lo_o !== m_lo || busy !== 1'b0) begin
            failures++;
            $display("FAIL mthi_after_reset got=%h_%h busy=%b want=%h_%h busy=0", hi_o, lo_o, busy, m_hi, m_lo);
        end
        $display("reset_mid_div then mthi hi=%h lo=%h", hi_o, lo_o);
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs;
        test_reset;
        test_mt;
        test_directed;
        test_random;
        test_stall_hilo;
        test_free_flow;
        test_back_to_back;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencer and HI/LO owner for the iterative multiply/divide unit of the 5-stage pipeline. It launches MULT/MULTU/DIV/DIVU from the EX stage, runs a 32-step shift-add / restoring-divide datapath, and raises a pipeline stall whenever an EX-stage instruction touches HI/LO while the unit is busy. The stall output is ORed with the load-use hold into PCWrite, IF_ID_Write and the ID/EX hold at the top level.

## Interface
- No parameters; width fixed at 32 (operands) and 64 (HI:LO).
- clk  input  1  pipeline clock, all state on rising edge
- rst_n  input  1  synchronous, active-low reset
- ex_inst  input  32  instruction word in ID/EX register
- ex_valid  input  1  ID/EX holds a real instruction; 0 for bubbles
- rs_val  input  32  forwarded rs operand in EX
- rt_val  input  32  forwarded rt operand in EX
- stall  output  1  hold PC, IF/ID and ID/EX this cycle (combinational)
- busy  output  1  iteration in progress (registered)
- hi_o  output  32  HI register
- lo_o  output  32  LO register

## Operation
- Decode, R-type only (ex_inst[31:26]==0, ex_valid==1): funct MULT 6'h18, MULTU 6'h19, DIV 6'h1A, DIVU 6'h1B, MFHI 6'h10, MTHI 6'h11, MFLO 6'h12, MTLO 6'h13. uses_hilo = any of the eight.
- stall = busy & uses_hilo. Nothing else stalls; MULT/DIV issuing to an idle unit does not stall.
- FSM states IDLE, BUSY.
- IDLE, EX holds MULT/MULTU/DIV/DIVU, not stalled: latch operands; signed ops latch magnitudes plus neg_q = sign(rs)^sign(rt) and neg_r = sign(rs); cnt<=0; go BUSY.
- IDLE, DIV/DIVU with rt_val==0: no BUSY; at the same edge HI<=rs_val, LO<=32'hFFFFFFFF; stay IDLE.
- IDLE, MTHI/MTLO: HI or LO <= rs_val at the edge. MFHI/MFLO read hi_o/lo_o combinationally in EX.
- BUSY: one step per cycle; cnt increments 0..31. Multiply: 64-bit shift-add on magnitudes. Divide: restoring, 33-bit partial remainder, one quotient bit per step.
- BUSY, cnt==31: at that edge write HI:LO (product, or HI=remainder, LO=quotient), applying two's-complement negation of the 64-bit product when neg_q (mult), quotient when neg_q and remainder when neg_r (div); go IDLE; busy falls.
- HI/LO are never written during BUSY except by the final step.
- Bubbles (ex_valid==0) never start, write or stall.
- Reset (any state, including mid-iteration): state IDLE, busy 0, stall 0, cnt 0, HI 0, LO 0, in-flight operation discarded.

## Timing
- Op in EX in cycle T, unit idle: busy=1 in T+1..T+32, HI/LO valid from T+33.
- MFHI/MFLO/MTHI/MTLO/MULT/DIV in EX during T+1..T+32: stall=1 through T+32, executes in T+33 (new op starts at the end of T+33).
- Back-to-back MULT in T and T+1: second stalls 32 cycles, starts at the end of T+33.
- Divide-by-zero: result visible in T+1, busy never asserted.
- Non-HI/LO instructions flow freely while busy.
- stall is purely combinational from busy and ex_inst/ex_valid; no registered stall.

## Structure
- FUNCT_MULT/MULTU/DIV/DIVU/MFHI/MTHI/MFLO/MTLO belong in define.v next to the existing FUNCT_JR/FUNCT_JALR.
- Sub-module muldiv_core: operand/accumulator registers, one-step mult/div logic, sign fix-up. Driven by start/op/step/finish from the FSM in muldiv_ctrl.
- muldiv_ctrl holds the FSM, cnt[4:0], decode, stall, HI/LO registers.

## Test plan
- MULT rs=32'hFFFFFFFE, rt=3 -> busy 32 cycles; HI=32'hFFFFFFFF, LO=32'hFFFFFFFA at T+33.
- MULTU same operands -> HI=32'h00000002, LO=32'hFFFFFFFA.
- DIV rs=32'hFFFFFFF9 (-7), rt=2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF. DIVU 100/7 -> LO=14, HI=2.
- DIVU rs=7, rt=0 -> no busy; HI=7, LO=32'hFFFFFFFF next cycle.
- MULT at T, MFLO at T+1 -> stall=1 for T+1..T+32; MFLO sees product at T+33. ADD at T+1 -> no stall. Bubble with MFLO bits and ex_valid=0 -> no stall.
- rst_n=0 at T+10 of a DIV -> next cycle busy=0, stall=0, HI=LO=0. MTHI 32'h12345678 after reset -> hi_o=32'h12345678 next cycle.
